// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// IF/ID presentation (valid/pc/instr) and its stall back-pressure.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        stall;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, stall
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_gnt, imem_rvalid, imem_rdata, stall
    );
endinterface

// File: rtl/if_fetch.sv
// In-order instruction fetch: PC register, 2-entry {pc,instr} response buffer,
// redirect flush. Defining IF_FETCH_PERF_EN adds fetch_cnt/bubble_cnt counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [XLEN-1:0] buf_instr [DEPTH];
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   osd;
    logic [CW-1:0]   drop;

    logic            pop;
    logic            wr;
    logic            acc;
    logic            wr_idx;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   osd_left;

    assign target = redirect_pc & ~XLEN'(3);
    // Requests since the last redirect are consecutive, so the oldest in-flight pc trails the PC.
    assign resp_pc  = pc - (XLEN'(osd) << 2);
    assign osd_left = osd - CW'(bus.imem_rvalid && (osd != '0));

    assign bus.if_valid = !rst && (cnt != '0);
    assign bus.if_pc    = bus.if_valid ? buf_pc[0]    : '0;
    assign bus.if_instr = bus.if_valid ? buf_instr[0] : '0;
    assign bus.imem_addr = pc;

    assign pop = bus.if_valid && !bus.stall;
    // A slot freed by this cycle's pop may be re-requested, which sustains one fetch per cycle.
    assign bus.imem_req = !rst && !redirect && (state == RUN) &&
                          (({1'b0, osd} + {1'b0, cnt} - 3'(pop)) < 3'(DEPTH));
    assign acc    = bus.imem_req && bus.imem_gnt;
    assign wr     = (state == RUN) && !redirect && bus.imem_rvalid && (osd != '0);
    assign wr_idx = 1'(cnt - CW'(pop));

    // Control state: PC, occupancy, outstanding and drop counters, RUN/FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            cnt   <= '0;
            osd   <= '0;
            drop  <= '0;
        end else if (redirect) begin
            pc    <= target;
            cnt   <= '0;
            osd   <= osd_left;
            drop  <= osd_left;
            state <= (osd_left != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (acc) pc <= pc + XLEN'(4);
                    osd <= osd + CW'(acc) - CW'(wr);
                    cnt <= cnt + CW'(wr) - CW'(pop);
                end
                FLUSH: begin
                    if (bus.imem_rvalid) begin
                        osd  <= osd_left;
                        drop <= drop - CW'(1);
                        if (drop == CW'(1)) state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Buffer payload; a write landing on slot 0 overrides the pop shift.
    always_ff @(posedge clk) begin
        if (pop) begin
            buf_pc[0]    <= buf_pc[1];
            buf_instr[0] <= buf_instr[1];
        end
        if (wr) begin
            buf_pc[wr_idx]    <= resp_pc;
            buf_instr[wr_idx] <= bus.imem_rdata;
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (pop) fetch_cnt <= fetch_cnt + XLEN'(1);
            if (!bus.if_valid && !bus.stall) bubble_cnt <= bubble_cnt + XLEN'(1);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a randomized memory model feeds responses, the
// expected fetch stream (consecutive pcs since the last redirect/reset) is queued.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    if_fetch_if bus ();
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IF_FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gnt_pct = 100, stall_pct = 0, lat_lo = 1, lat_hi = 1, redir_pct = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_a[$];
    int          pend_d[$];
    logic [31:0] model_pc = RESET_PC;
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] mon_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1357;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle's inputs after the edge, then record its handshakes at mid-cycle.
    task automatic tick(input bit rs = 1'b0, input bit rd = 1'b0,
                        input logic [31:0] tgt = '0, input bit stale = 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        rst = rs;
        redirect = rd || (redir_pct != 0 && int'($urandom_range(99)) < redir_pct);
        redirect_pc = rd ? tgt : 32'($urandom());
        bus.imem_gnt = int'($urandom_range(99)) < gnt_pct;
        bus.stall = int'($urandom_range(99)) < stall_pct;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'($urandom());
        if (stale) begin
            bus.imem_rvalid = 1'b1;
        end else if (pend_d.size() != 0 && pend_d[0] <= cyc) begin
            void'(pend_d.pop_front());
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = instr_of(pend_a.pop_front());
        end
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            pend_a.delete();
            pend_d.delete();
            model_pc = RESET_PC;
        end else if (redirect) begin
            check("req_during_redirect", 32'(bus.imem_req), 32'd0);
            exp_q.delete();
            model_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (bus.imem_req && bus.imem_gnt) begin
            check("req_addr", bus.imem_addr, model_pc);
            exp_q.push_back(model_pc);
            pend_a.push_back(model_pc);
            pend_d.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            model_pc += 32'd4;
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!bus.if_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.if_valid), 32'd1);
    endtask

    // Monitor: every pop must be the next queued pc with its memory word; stalled heads hold.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !redirect) begin
                if (hold_v) begin
                    check("stall_hold_valid", 32'(bus.if_valid), 32'd1);
                    check("stall_hold_pc", bus.if_pc, hold_pc);
                end
                if (bus.if_valid && !bus.stall) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 32'(bus.if_valid), 32'd0);
                    end else begin
                        mon_pc = exp_q.pop_front();
                        check("pop_pc", bus.if_pc, mon_pc);
                        check("pop_instr", bus.if_instr, instr_of(mon_pc));
                    end
                end
            end
            hold_v = !rst && !redirect && bus.if_valid && bus.stall;
            hold_pc = bus.if_pc;
        end
    end

    initial begin
        int n;
        bit found;
        logic [31:0] hpc;
        logic [31:0] hin;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.stall = 1'b0;

        tick(1'b1);
        tick(1'b1);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_instr", bus.if_instr, 32'd0);
        check("rst_addr", bus.imem_addr, RESET_PC);

        // 1-cycle memory, grant always: valid two cycles after the first grant, then one per cycle
        tick();
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, RESET_PC);
        tick();
        check("lat_c1_valid", 32'(bus.if_valid), 32'd0);
        tick();
        check("lat_c2_valid", 32'(bus.if_valid), 32'd1);
        check("seq_pc0", bus.if_pc, 32'h0);
        tick();
        check("seq_pc1", bus.if_pc, 32'h4);
        tick();
        check("seq_pc2", bus.if_pc, 32'h8);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sustain_valid", 32'(bus.if_valid), 32'd1);
        end

        // Stall with the buffer full
        stall_pct = 100;
        tick();
        hpc = bus.if_pc;
        hin = bus.if_instr;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc", bus.if_pc, hpc);
            check("stall_instr", bus.if_instr, hin);
            check("stall_req", 32'(bus.imem_req), 32'd0);
        end
        stall_pct = 0;
        tick();
        check("release_pc0", bus.if_pc, hpc);
        tick();
        check("release_pc1", bus.if_pc, hpc + 32'd4);
        tick();
        check("release_pc2", bus.if_pc, hpc + 32'd8);

        // Redirect with two requests in flight
        lat_lo = 3;
        lat_hi = 3;
        n = 0;
        while (pend_a.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("inflight_two", 32'(pend_a.size()), 32'd2);
        tick(1'b0, 1'b1, 32'h0000_1003);
        wait_valid("redir_target_valid", 20);
        check("redir_target_pc", bus.if_pc, 32'h0000_1000);
        lat_lo = 1;
        lat_hi = 1;

        // Redirect while stalled
        stall_pct = 100;
        wait_valid("rs_setup_valid", 20);
        tick(1'b0, 1'b1, 32'h0000_2000);
        tick();
        check("rs_valid_next", 32'(bus.if_valid), 32'd0);
        stall_pct = 0;
        wait_valid("rs_target_valid", 20);
        check("rs_target_pc", bus.if_pc, 32'h0000_2000);

        // PC wrap
        tick(1'b0, 1'b1, 32'hFFFF_FFF8);
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            tick();
            n++;
            found = bus.imem_req && bus.imem_gnt && (bus.imem_addr == 32'hFFFF_FFFC);
        end
        check("wrap_seen", 32'(found), 32'd1);
        tick();
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Mid-operation reset with stale responses during and right after reset
        lat_lo = 2;
        lat_hi = 2;
        for (int i = 0; i < 5; i++) tick();
        tick(1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_mid_valid", 32'(bus.if_valid), 32'd0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_rel_req", 32'(bus.imem_req), 32'd1);
        check("rst_rel_addr", bus.imem_addr, RESET_PC);
        wait_valid("rst_rel_valid", 20);
        check("rst_rel_pc", bus.if_pc, RESET_PC);
        lat_lo = 1;
        lat_hi = 1;

`ifdef IF_FETCH_PERF_EN
        // 3 bubble cycles then 10 pops
        gnt_pct = 0;
        tick(1'b1);
        tick(1'b1);
        tick();
        gnt_pct = 100;
        tick();
        tick();
        for (int i = 0; i < 10; i++) tick();
        stall_pct = 100;
        tick();
        check("perf_fetch_cnt", fetch_cnt, 32'd10);
        check("perf_bubble_cnt", bubble_cnt, 32'd3);
        tick(1'b1);
        tick(1'b1);
        check("perf_fetch_rst", fetch_cnt, 32'd0);
        check("perf_bubble_rst", bubble_cnt, 32'd0);
        stall_pct = 0;
        tick();
`endif

        // Randomized traffic: grant gaps, variable latency, stalls, redirects
        gnt_pct = 70;
        stall_pct = 30;
        lat_lo = 1;
        lat_hi = 4;
        redir_pct = 3;
        for (int i = 0; i < 3000; i++) tick();

        // Drain: with grants withheld every granted, unflushed fetch must come out
        redir_pct = 0;
        stall_pct = 0;
        gnt_pct = 0;
        for (int i = 0; i < 15; i++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port stall, input, 1 bit: downstream IF/ID register not accepting (hazard unit).
REQ-005 The module SHALL have port redirect, input, 1 bit: taken branch/jump from a later stage; flushes fetch.
REQ-006 The module SHALL have port redirect_pc, input, 32 bits: new fetch address; bits [1:0] ignored, treated as 0.
REQ-007 The module SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): instruction memory request and word address.
REQ-008 The module SHALL have port imem_gnt, input, 1 bit: a request is accepted in any cycle where imem_req and imem_gnt are both 1.
REQ-009 The module SHALL have ports imem_rvalid (input, 1 bit) and imem_rdata (input, 32 bits): in-order response, latency >= 1 cycle after grant.
REQ-010 The module SHALL have ports if_valid (output, 1 bit), if_pc (output, 32 bits) and if_instr (output, 32 bits): the fetched instruction presented to the IF/ID register.

Function
REQ-011 The module SHALL hold a PC register; each accepted request SHALL advance the PC by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-012 The module SHALL drive imem_addr with the PC at all times.
REQ-013 The module SHALL keep a 2-entry in-order buffer of {pc, instr}, written on imem_rvalid in RUN state.
REQ-014 The module SHALL assert imem_req only in RUN state, only when redirect is 0, and only when outstanding requests plus buffered entries < 2, so a response always finds space.
REQ-015 The module SHALL drive if_valid, if_pc and if_instr from the buffer head, combinationally, with no extra register.
REQ-016 The module SHALL pop the head in any cycle with if_valid=1 and stall=0; the head SHALL stay stable while stall=1.
REQ-017 The module SHALL support a simultaneous pop and write in one cycle with the buffer full, preserving order.
REQ-018 The FSM SHALL have states RUN and FLUSH, and reset SHALL enter RUN.
REQ-019 On redirect=1 in any state: the PC SHALL load {redirect_pc[31:2],2'b00}, the buffer SHALL be cleared, and the drop count SHALL be set to the number of in-flight requests, not counting any rvalid arriving that same cycle.
REQ-020 After a redirect, the FSM SHALL enter FLUSH if the resulting drop count > 0, otherwise RUN.
REQ-021 In FLUSH, each imem_rvalid SHALL be discarded and SHALL decrement the drop count; at 0 the FSM SHALL return to RUN with no request issued in the same cycle.
REQ-022 When redirect and stall are both 1, redirect SHALL take priority; if_valid SHALL be 0 in the next cycle.
REQ-023 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-024 Minimum latency SHALL be: with a 1-cycle memory and no stall, if_valid rises 2 cycles after the grant, and one instruction per cycle is sustained.

Reset
REQ-025 While rst=1: PC=RESET_PC, buffer empty, outstanding=0, drop count=0, state RUN, imem_req=0, if_valid=0, if_pc=0, if_instr=0.
REQ-026 When rst is asserted mid-operation, the module SHALL discard all in-flight responses; after release, the first request SHALL be for RESET_PC one cycle later, and rvalid pulses from before reset SHALL be ignored.

Configuration
REQ-027 When macro IF_FETCH_PERF_EN is defined, the module SHALL add outputs fetch_cnt[31:0] (increments per popped instruction) and bubble_cnt[31:0] (increments per cycle with if_valid=0 and stall=0), both wrapping and cleared by rst.
REQ-028 When IF_FETCH_PERF_EN is undefined, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-029 The bench SHALL cover: reset, then 1-cycle memory with gnt always 1 -> if_pc sequence 0x0, 0x4, 0x8, one per cycle, starting 2 cycles after the first grant.
REQ-030 The bench SHALL cover: stall held 5 cycles with the buffer full -> if_pc/if_instr constant, imem_req=0, no entry lost after release.
REQ-031 The bench SHALL cover: redirect to 0x0000_1003 with 2 requests in flight -> both responses discarded, next if_pc=0x0000_1000.
REQ-032 The bench SHALL cover: redirect and stall together -> if_valid=0 next cycle, then the redirect target is fetched.
REQ-033 The bench SHALL cover: PC=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-034 The bench SHALL cover: with IF_FETCH_PERF_EN, 10 pops and 3 bubble cycles -> fetch_cnt=10, bubble_cnt=3; rst clears both to 0.
